// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_mem_arbiter
// Description : Shares one line-wide memory port between the instruction
//               cache (reads only) and the data cache (reads and write-backs).
//               The arbiter grants one requester, latches its request and
//               drives memory until mem_resp. It then returns the line and a
//               one-cycle response pulse to that requester only.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter #(
    parameter int LINE_W   = 256,
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    // instruction cache side
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    // data cache side
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    // physical memory side
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    // Clears the byte-offset bits so memory always sees a line-aligned address.
    localparam logic [ADDR_W-1:0] c_align_mask =
        {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t r_state;
    logic   r_grant_d;   // 1: data cache owns the current transaction
    logic   r_last_d;    // 1: last grant went to the data cache

    logic   w_i_pend;
    logic   w_d_pend;
    logic   w_pick_d;

    assign w_i_pend = i_read;
    assign w_d_pend = d_read | d_write;
    // Round-robin: a lone requester always wins; on a tie the one that was
    // not served last wins.
    assign w_pick_d = w_d_pend & (~w_i_pend | ~r_last_d);

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_grant_d <= 1'b0;
            r_last_d  <= 1'b0;
            i_rdata   <= '0;
            i_resp    <= 1'b0;
            d_rdata   <= '0;
            d_resp    <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_i_pend || w_d_pend) begin
                        r_grant_d <= w_pick_d;
                        r_last_d  <= w_pick_d;
                        if (w_pick_d) begin
                            mem_addr <= d_addr & c_align_mask;
                            // A simultaneous read and write is a write-back.
                            if (d_write) begin
                                mem_write <= 1'b1;
                                mem_wdata <= d_wdata;
                            end else begin
                                mem_read  <= 1'b1;
                            end
                        end else begin
                            mem_addr <= i_addr & c_align_mask;
                            mem_read <= 1'b1;
                        end
                        r_state <= ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    if (mem_resp) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        // Only reads update the requester's line register.
                        if (mem_read) begin
                            if (r_grant_d) begin
                                d_rdata <= mem_rdata;
                            end else begin
                                i_rdata <= mem_rdata;
                            end
                        end
                        if (r_grant_d) begin
                            d_resp <= 1'b1;
                        end else begin
                            i_resp <= 1'b1;
                        end
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    i_resp  <= 1'b0;
                    d_resp  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_mem_arbiter
// Description : Scoreboard bench for cache_mem_arbiter. Directed requests push
//               the expected memory transaction and the expected response;
//               a memory model and a response monitor pop and compare.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_mem_arbiter;

    localparam int LINE_W   = 256;
    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 5;

    localparam logic [LINE_W-1:0] JUNK   = {8{32'hDEAD_BEEF}};
    localparam logic [LINE_W-1:0] PAT_A5 = {32{8'hA5}};
    localparam logic [LINE_W-1:0] PAT_WB = {8{32'h1122_33FF}};

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_read = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read = 1'b0;
    logic              d_write = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [LINE_W-1:0] d_wdata = '0;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata = JUNK;
    logic              mem_resp;
    logic              mem_resp_m = 1'b0;
    logic              mem_resp_stray = 1'b0;

    assign mem_resp = mem_resp_m | mem_resp_stray;

    cache_mem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
        logic [LINE_W-1:0] rdata;
        int                lat;
    } mem_txn_t;

    typedef struct {
        logic              is_d;
        logic [LINE_W-1:0] i_exp;
        logic [LINE_W-1:0] d_exp;
    } resp_t;

    mem_txn_t          mem_q[$];
    resp_t             resp_q[$];
    logic [LINE_W-1:0] model_i = '0;
    logic [LINE_W-1:0] model_d = '0;
    int                n_tests = 0;
    int                n_fail  = 0;

    task automatic check(input string name, input logic [LINE_W-1:0] act,
                         input logic [LINE_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Queue one granted transaction: what memory should see and what the
    // requester should get back (snapshot of both line registers).
    task automatic expect_txn(input logic is_d, input logic wr, input logic [ADDR_W-1:0] addr,
                              input logic [LINE_W-1:0] wdata, input logic [LINE_W-1:0] rdata,
                              input int lat);
        mem_txn_t m;
        resp_t    r;
        m.wr = wr; m.addr = addr; m.wdata = wdata; m.rdata = rdata; m.lat = lat;
        mem_q.push_back(m);
        if (!wr) begin
            if (is_d) model_d = rdata;
            else      model_i = rdata;
        end
        r.is_d = is_d; r.i_exp = model_i; r.d_exp = model_d;
        resp_q.push_back(r);
    endtask

    // Memory model: checks each operation and answers after its latency.
    initial begin : mem_model
        mem_txn_t e;
        logic     aborted;
        forever begin
            @(negedge clk);
            if (mem_read && mem_write) fail("mem_exclusive");
            if (rst_n && (mem_read || mem_write)) begin
                if (mem_q.size() == 0) begin
                    fail("mem_unexpected_op");
                end else begin
                    e = mem_q.pop_front();
                    check("mem_op", {mem_read, mem_write}, {!e.wr, e.wr});
                    check("mem_addr", mem_addr, e.addr);
                    if (e.wr) check("mem_wdata", mem_wdata, e.wdata);
                    aborted = 1'b0;
                    for (int c = 1; c < e.lat; c++) begin
                        @(negedge clk);
                        if (!rst_n) begin
                            aborted = 1'b1;
                            break;
                        end
                        check("mem_hold", {mem_read, mem_write, mem_addr},
                              {!e.wr, e.wr, e.addr});
                    end
                    if (!aborted) begin
                        mem_rdata  = e.rdata;
                        mem_resp_m = 1'b1;
                        @(negedge clk);
                        mem_resp_m = 1'b0;
                        mem_rdata  = JUNK;
                        if (rst_n) check("mem_op_in_resp", {mem_read, mem_write}, 2'b00);
                    end
                end
            end
        end
    end

    // Response monitor: pops the scoreboard whenever a resp pulse appears.
    initial begin : resp_monitor
        resp_t r;
        forever begin
            @(negedge clk);
            if (i_resp && d_resp) begin
                fail("resp_exclusive");
            end else if (i_resp || d_resp) begin
                if (resp_q.size() == 0) begin
                    fail("resp_unexpected");
                end else begin
                    r = resp_q.pop_front();
                    check("resp_who", d_resp, r.is_d);
                    check("i_rdata", i_rdata, r.i_exp);
                    check("d_rdata", d_rdata, r.d_exp);
                end
            end
        end
    end

    // icache requester; exp_lat>0 also checks request-to-resp cycles and
    // scrambles the address once the grant has been taken.
    task automatic run_i(input logic [ADDR_W-1:0] addr, input int exp_lat);
        int  cyc;
        bit  seen;
        @(posedge clk); #1;
        i_read = 1'b1; i_addr = addr;
        seen = 0; cyc = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (k == 1 && exp_lat > 0) i_addr = ~addr;
            if (i_resp) begin
                seen = 1; cyc = k;
                break;
            end
        end
        if (!seen) fail("i_timeout");
        else if (exp_lat > 0) check("i_latency", cyc, exp_lat);
        @(posedge clk); #1;
        i_read = 1'b0;
    endtask

    // dcache requester.
    task automatic run_d(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                         input logic [LINE_W-1:0] wdata, input int exp_lat);
        int  cyc;
        bit  seen;
        @(posedge clk); #1;
        d_read = rd; d_write = wr; d_addr = addr; d_wdata = wdata;
        seen = 0; cyc = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (k == 1 && exp_lat > 0) begin
                d_addr = ~addr; d_wdata = ~wdata;
            end
            if (d_resp) begin
                seen = 1; cyc = k;
                break;
            end
        end
        if (!seen) fail("d_timeout");
        else if (exp_lat > 0) check("d_latency", cyc, exp_lat);
        @(posedge clk); #1;
        d_read = 1'b0; d_write = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctrl"}, {i_resp, d_resp, mem_read, mem_write, mem_addr}, '0);
        check({name, "_i_rdata"}, i_rdata, '0);
        check({name, "_d_rdata"}, d_rdata, '0);
        check({name, "_mem_wdata"}, mem_wdata, '0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_i = '0;
        model_d = '0;
        check_all_zero("reset");
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [31:0]       w;
        logic [LINE_W-1:0] dat;
        bit                seen;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check_all_zero("por");

        // Single icache read, offset bits dropped, 4-cycle memory.
        expect_txn(1'b0, 1'b0, 32'h0000_1040, '0, PAT_A5, 4);
        run_i(32'h0000_104C, 5);

        // Dcache write-back; d_rdata stays at its reset value.
        expect_txn(1'b1, 1'b1, 32'h8000_0020, PAT_WB, '0, 3);
        run_d(1'b0, 1'b1, 32'h8000_0020, PAT_WB, 4);

        // Simultaneous requests after reset: D first, then I, three rounds.
        do_reset();
        for (int r = 0; r < 3; r++) begin
            w   = 32'hD000_0000 + r;
            dat = {8{w}};
            expect_txn(1'b1, 1'b0, 32'h0000_2000 + 32'(r * 64), '0, dat, 2);
            expect_txn(1'b0, 1'b0, 32'h0000_3000 + 32'(r * 64), '0, ~dat, 1);
            fork
                run_d(1'b1, 1'b0, 32'h0000_2007 + 32'(r * 64), '0, 0);
                run_i(32'h0000_301F + 32'(r * 64), 0);
            join
        end

        // Back-to-back dcache reads, second at minimum latency.
        expect_txn(1'b1, 1'b0, 32'h0000_4000, '0, {8{32'h0BAD_F00D}}, 2);
        run_d(1'b1, 1'b0, 32'h0000_4004, '0, 3);
        expect_txn(1'b1, 1'b0, 32'h0000_4020, '0, {8{32'h600D_CAFE}}, 1);
        run_d(1'b1, 1'b0, 32'h0000_4020, '0, 2);

        // Stray mem_resp while idle must do nothing.
        @(posedge clk); #1 mem_resp_stray = 1'b1;
        @(posedge clk); #1 mem_resp_stray = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("stray_ctrl", {i_resp, d_resp, mem_read, mem_write}, 4'b0000);
            check("stray_i_rdata", i_rdata, model_i);
            check("stray_d_rdata", d_rdata, model_d);
        end

        // d_read and d_write together behave as a write-back.
        expect_txn(1'b1, 1'b1, 32'h0000_5040, {8{32'h5A5A_0001}}, '0, 3);
        run_d(1'b1, 1'b1, 32'h0000_5041, {8{32'h5A5A_0001}}, 4);

        // Reset while mem_read is high abandons the transaction silently.
        begin
            mem_txn_t m;
            m.wr = 1'b0; m.addr = 32'h0000_6000; m.wdata = '0; m.rdata = JUNK; m.lat = 10;
            mem_q.push_back(m);
        end
        @(posedge clk); #1;
        i_read = 1'b1; i_addr = 32'h0000_6010;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (mem_read) begin
                seen = 1;
                break;
            end
        end
        if (!seen) fail("midreset_no_mem_read");
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        i_read = 1'b0;
        model_i = '0;
        model_d = '0;
        check_all_zero("midreset");

        // Fresh icache read after the abandoned one.
        expect_txn(1'b0, 1'b0, 32'h0000_7000, '0, {8{32'h7777_0001}}, 2);
        run_i(32'h0000_7008, 3);

        repeat (5) @(negedge clk);
        check("queues_empty", 32'(mem_q.size() + resp_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
